// File: rtl/cam_reg_config_ctrl.sv
// Camera sensor register configuration sequencer: walks a {register, value} ROM
// and issues one SCCB write per entry through the sender's send/taken handshake.
module cam_reg_config_ctrl #(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int unsigned PWRUP_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES   = 256,
  parameter int unsigned DELAY_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              send,
  output logic [7:0]        id,
  output logic [7:0]        register,
  output logic [7:0]        value,
  input  logic              taken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cmd_count
);

  typedef enum logic [2:0] {
    IDLE, PWRUP, READ, DECODE, SEND, GAP, DELAY, DONE
  } state_t;

  // Terminal counts; a zero-length wait still spends one cycle in its state.
  localparam int unsigned PWRUP_LAST = (PWRUP_CYCLES == 0) ? 0 : PWRUP_CYCLES - 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES   == 0) ? 0 : GAP_CYCLES   - 1;
  localparam int unsigned DELAY_LAST = (DELAY_CYCLES == 0) ? 0 : DELAY_CYCLES - 1;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] cmd_q, cmd_d;
  logic              send_q, send_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      cmd_q      <= '0;
      send_q     <= 1'b0;
      reg_q      <= '0;
      val_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      cmd_q      <= cmd_d;
      send_q     <= send_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    rom_addr_d = rom_addr_q;
    cmd_d      = cmd_q;
    send_d     = send_q;
    reg_d      = reg_q;
    val_d      = val_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = PWRUP;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          rom_addr_d = '0;
          cmd_d      = '0;
        end
      end
      PWRUP: begin
        if (cnt_q == PWRUP_LAST) state_d = READ;
        else                     cnt_d   = cnt_q + 32'd1;
      end
      READ: state_d = DECODE;
      DECODE: begin
        if (rom_data == END_MARK) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (rom_data == DELAY_MARK) begin
          state_d = DELAY;
        end else begin
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (taken) begin
          send_d  = 1'b0;
          state_d = GAP;
          if (cmd_q != '1) cmd_d = cmd_q + ADDR_W'(1);
        end
      end
      GAP, DELAY: begin
        // Both waits end the same way: next entry, or finish at the last ROM slot.
        if (cnt_q == ((state_q == GAP) ? GAP_LAST : DELAY_LAST)) begin
          if (rom_addr_q == '1) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = READ;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign send      = send_q;
  assign id        = DEV_ID;
  assign register  = reg_q;
  assign value     = val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_count = cmd_q;

endmodule

// File: tb/tb_cam_reg_config_ctrl.sv
// Bench for cam_reg_config_ctrl: ROM-table walk model with cycle-exact timing
// predicted from the wait lengths, plus a sender model with variable latency.
module tb_cam_reg_config_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned PWRUP = 16;
  localparam int unsigned GAP   = 4;
  localparam int unsigned DELAY = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          send;
  logic [7:0]    id;
  logic [7:0]    register;
  logic [7:0]    value;
  logic          taken;
  logic          busy;
  logic          done;
  logic [AW-1:0] cmd_count;

  cam_reg_config_ctrl #(
    .ADDR_W(AW), .DEV_ID(8'h42), .PWRUP_CYCLES(PWRUP),
    .GAP_CYCLES(GAP), .DELAY_CYCLES(DELAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .send(send), .id(id), .register(register),
    .value(value), .taken(taken), .busy(busy), .done(done),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int unsigned rises = 0;
  logic send_prev = 1'b0;
  always @(negedge clk) begin
    if (send && !send_prev) rises <= rises + 1;
    send_prev <= send;
  end

  int n_checks = 0;
  int n_errors = 0;
  int lat [4];
  logic [7:0] last_reg, last_val;
  bit have_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int unsigned k);
    while (cyc < k) @(negedge clk);
  endtask

  function automatic logic [31:0] sat(input int unsigned n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  function automatic logic [15:0] rand_entry();
    logic [15:0] w;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'hFFFF;
    if (r <= 2) return 16'hFFF0;
    w = 16'($urandom);
    if (w[15:4] == 12'hFFF) w[15] = 1'b0;
    return w;
  endfunction

  // One pass: start, then predict every send/done edge from the table contents.
  task automatic run_pass(input int rst_entry, input bit stray);
    int unsigned s, t, de, n, r0, exp_addr;
    bit fin;
    logic [15:0] w;
    if (have_done) check("done_hold", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_addr", rom_addr, 0);
    check("start_cmd", cmd_count, 0);
    check("start_send", send, 0);
    r0 = rises;
    if (stray) begin
      wait_to(s + 5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(s + 8);
      taken = 1'b1;
      @(negedge clk);
      taken = 1'b0;
    end
    t = s + PWRUP + 2;
    n = 0; fin = 0; de = 0; exp_addr = 3;
    for (int i = 0; i < 4 && !fin; i++) begin
      w = rom[i];
      if (w == 16'hFFFF) begin
        de = t; exp_addr = i; fin = 1;
      end else if (w == 16'hFFF0) begin
        if (i == 3) de = t + DELAY;
        else        t  = t + DELAY + 2;
      end else begin
        wait_to(t - 1);
        check("send_early", send, 0);
        wait_to(t);
        check("send_rise", send, 1);
        check("register", register, w[15:8]);
        check("value", value, w[7:0]);
        last_reg = w[15:8];
        last_val = w[7:0];
        if (i == rst_entry) begin
          rst_n = 1'b0;
          #1;
          check("rst_send", send, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_addr", rom_addr, 0);
          check("rst_cmd", cmd_count, 0);
          check("rst_reg", register, 0);
          @(negedge clk);
          rst_n = 1'b1;
          last_reg = '0;
          last_val = '0;
          have_done = 0;
          return;
        end
        for (int k = 1; k < lat[i]; k++) begin
          check("send_hold", send, 1);
          @(negedge clk);
        end
        check("send_hold", send, 1);
        taken = 1'b1;
        @(negedge clk);
        taken = 1'b0;
        check("send_fall", send, 0);
        n++;
        check("cmd_count", cmd_count, sat(n));
        if (i == 3) de = cyc + GAP;
        else        t  = cyc + GAP + 2;
      end
    end
    wait_to(de - 1);
    check("done_early", done, 0);
    check("busy_early", busy, 1);
    wait_to(de);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("cmd_final", cmd_count, sat(n));
    check("addr_final", rom_addr, exp_addr);
    check("reg_hold", register, last_reg);
    check("val_hold", value, last_val);
    @(negedge clk);
    check("write_count", rises - r0, n);
    have_done = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; taken = 1'b0;
    last_reg = '0; last_val = '0; have_done = 0;
    foreach (rom[i]) rom[i] = 16'hFFFF;
    foreach (lat[i]) lat[i] = 3;
    repeat (3) @(negedge clk);
    check("rst_send", send, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_cmd", cmd_count, 0);
    check("rst_reg", register, 0);
    check("rst_val", value, 0);
    check("id", id, 8'h42);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF};
    run_pass(-1, 0);
    repeat (3) @(negedge clk);

    rom = '{16'h1180, 16'hFFF0, 16'h3A04, 16'hFFFF};
    run_pass(-1, 1);

    rom = '{16'h5511, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    lat[0] = 500;
    run_pass(-1, 0);
    lat[0] = 3;

    rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF};
    run_pass(1, 0);
    repeat (2) @(negedge clk);
    run_pass(-1, 0);

    rom = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    run_pass(-1, 1);

    rom = '{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0};
    run_pass(-1, 0);

    for (int p = 0; p < 20; p++) begin
      foreach (rom[i]) rom[i] = rand_entry();
      foreach (lat[i]) lat[i] = $urandom_range(1, 8);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_pass(-1, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
